// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared constants, tracker state and history entry type
package mastermind_pkg;
  localparam int PEG_W = 3;
  localparam int NUM_PEGS = 4;
  localparam int CODE_W = NUM_PEGS * PEG_W;
  typedef enum logic [1:0] {PLAY, WIN, LOSE} tracker_state_t;
  typedef struct packed {
    logic [CODE_W-1:0] guess;
    logic [2:0] red;
    logic [2:0] white;
  } hist_entry_t;
endpackage

// File: rtl/mastermind_round_tracker_if.sv
// mastermind_round_tracker_if: result input, history read port and game status
interface mastermind_round_tracker_if
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8
);
  localparam int CNT_W = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W = $clog2(MAX_GUESSES);
  logic new_game;
  logic result_valid;
  logic [CODE_W-1:0] guess;
  logic [2:0] red;
  logic [2:0] white;
  logic [IDX_W-1:0] hist_sel;
  logic [CODE_W-1:0] hist_guess;
  logic [2:0] hist_red;
  logic [2:0] hist_white;
  logic hist_valid;
  logic [CNT_W-1:0] guess_count;
  logic [2:0] last_red;
  logic [2:0] last_white;
  logic win;
  logic lose;
  logic game_over;
  logic bad_result;
  modport master (
    output new_game, result_valid, guess, red, white, hist_sel,
    input hist_guess, hist_red, hist_white, hist_valid, guess_count,
    input last_red, last_white, win, lose, game_over, bad_result
  );
  modport slave (
    input new_game, result_valid, guess, red, white, hist_sel,
    output hist_guess, hist_red, hist_white, hist_valid, guess_count,
    output last_red, last_white, win, lose, game_over, bad_result
  );
endinterface

// File: rtl/mastermind_history_ram.sv
// mastermind_history_ram: guess history with per-entry valid bits and a registered read port
module mastermind_history_ram
  import mastermind_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  hist_entry_t      wdata,
  input  logic             clr,
  input  logic [IDX_W-1:0] raddr,
  output hist_entry_t      rdata,
  output logic             rvalid
);
  hist_entry_t mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic in_range;
  assign in_range = {1'b0, raddr} < (IDX_W + 1)'(DEPTH);
  // entry data is never cleared; the valid bits alone say what is live
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // valid bits: cleared on a new game, set as entries are written
  always_ff @(posedge clk or posedge reset)
    if (reset) vld <= '0;
    else if (clr) vld <= '0;
    else if (we) vld[waddr] <= 1'b1;
  // read register sees pre-write contents on a same-index collision
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rdata <= '0;
      rvalid <= 1'b0;
    end else begin
      rdata <= in_range ? mem[raddr] : '0;
      rvalid <= in_range && vld[raddr];
    end
endmodule

// File: rtl/mastermind_round_tracker.sv
// mastermind_round_tracker: logs scored guesses, counts them and decides win or loss
module mastermind_round_tracker
  import mastermind_pkg::*;
#(
  parameter int MAX_GUESSES = 8
) (
  input logic clk,
  input logic reset,
  mastermind_round_tracker_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_GUESSES + 1);
  localparam int IDX_W = $clog2(MAX_GUESSES);
  tracker_state_t state;
  hist_entry_t wd, rd;
  logic [3:0] fb_sum;
  logic legal, strobe, accept;
  assign fb_sum = {1'b0, bus.red} + {1'b0, bus.white};
  assign legal = bus.red <= 3'(NUM_PEGS) && fb_sum <= 4'(NUM_PEGS);
  assign strobe = bus.result_valid && !bus.new_game && state == PLAY;
  assign accept = strobe && legal;
  assign wd = '{guess: bus.guess, red: bus.red, white: bus.white};
  mastermind_history_ram #(.DEPTH(MAX_GUESSES), .IDX_W(IDX_W)) u_hist (
    .clk(clk),
    .reset(reset),
    .we(accept),
    .waddr(bus.guess_count[IDX_W-1:0]),
    .wdata(wd),
    .clr(bus.new_game),
    .raddr(bus.hist_sel),
    .rdata(rd),
    .rvalid(bus.hist_valid)
  );
  assign bus.hist_guess = rd.guess;
  assign bus.hist_red = rd.red;
  assign bus.hist_white = rd.white;
  assign bus.game_over = bus.win | bus.lose;
  // game FSM with counter, last feedback and registered status flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= PLAY;
      bus.guess_count <= '0;
      bus.last_red <= '0;
      bus.last_white <= '0;
      bus.win <= 1'b0;
      bus.lose <= 1'b0;
      bus.bad_result <= 1'b0;
    end else if (bus.new_game) begin
      state <= PLAY;
      bus.guess_count <= '0;
      bus.last_red <= '0;
      bus.last_white <= '0;
      bus.win <= 1'b0;
      bus.lose <= 1'b0;
      bus.bad_result <= 1'b0;
    end else begin
      bus.bad_result <= strobe && !legal;
      if (accept) begin
        bus.guess_count <= bus.guess_count + 1'b1;
        bus.last_red <= bus.red;
        bus.last_white <= bus.white;
        if (bus.red == 3'(NUM_PEGS)) begin
          state <= WIN;
          bus.win <= 1'b1;
        end else if (bus.guess_count + 1'b1 == CNT_W'(MAX_GUESSES)) begin
          state <= LOSE;
          bus.lose <= 1'b1;
        end
      end
    end
endmodule
